// File: rtl/display_scan_controller.sv
// display_scan_controller
// Time-multiplexed scan driver for a four-digit seven-segment display.
// Steps a 2-bit Gray-coded mux select through digits 0..3, drives the
// matching active-low digit enable after a blanking gap at the start of
// each slot, and emits slot/frame strobes. Every output is registered.
module display_scan_controller #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] blank_mask,
  output logic [1:0] select,
  output logic [3:0] digit_n,
  output logic       slot_tick,
  output logic       frame_tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } run_state_t;

  // Complete scan position; held in one struct so the whole FSM state
  // can be probed by name from a checker or waveform viewer.
  typedef struct packed {
    run_state_t       run;
    logic [CW-1:0]    cnt;
    logic [1:0]       k;
  } scan_state_t;

  scan_state_t cur_state;
  scan_state_t nxt_state;

  logic       nxt_show;
  logic [1:0] nxt_select;
  logic [3:0] nxt_digit_n;

  // Next scan position: any low enable forces IDLE at slot 0 / cycle 0,
  // so a restart never resumes a partial slot.
  always_comb begin
    nxt_state = cur_state;
    if (!enable) begin
      nxt_state.run = IDLE;
      nxt_state.cnt = '0;
      nxt_state.k   = 2'd0;
    end else if (cur_state.run == IDLE) begin
      nxt_state.run = SCAN;
      nxt_state.cnt = '0;
      nxt_state.k   = 2'd0;
    end else if (cur_state.cnt == CNT_LAST) begin
      nxt_state.cnt = '0;
      nxt_state.k   = cur_state.k + 2'd1;
    end else begin
      nxt_state.cnt = cur_state.cnt + 1'b1;
    end
  end

  // Output values for the upcoming cycle, derived from the next position
  // so the registered outputs line up with the state they describe.
  always_comb begin
    nxt_select  = {nxt_state.k[1], nxt_state.k[1] ^ nxt_state.k[0]};
    nxt_show    = (int'(nxt_state.cnt) >= BLANK_CYCLES) && !blank_mask[nxt_state.k];
    nxt_digit_n = 4'b1111;
    if (nxt_show) begin
      nxt_digit_n = ~(4'b0001 << nxt_state.k);
    end
  end

  // Scan FSM with registered outputs; reset drives IDLE values at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state.run <= IDLE;
      cur_state.cnt <= '0;
      cur_state.k   <= 2'd0;
      select        <= 2'b00;
      digit_n       <= 4'b1111;
      slot_tick     <= 1'b0;
      frame_tick    <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (nxt_state.run == SCAN) begin
        select     <= nxt_select;
        digit_n    <= nxt_digit_n;
        slot_tick  <= (nxt_state.cnt == '0);
        frame_tick <= (nxt_state.cnt == '0) && (nxt_state.k == 2'd0);
      end else begin
        select     <= 2'b00;
        digit_n    <= 4'b1111;
        slot_tick  <= 1'b0;
        frame_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller
// Directed bench for display_scan_controller. Two instances: the default
// test configuration (CLK_DIV=8, BLANK_CYCLES=2) and a gapless one
// (CLK_DIV=4, BLANK_CYCLES=0). Each stimulus step pushes the expected
// output vector {select, digit_n, slot_tick, frame_tick} for the cycle it
// produces, tagged with which instance to watch; a monitor pops and
// compares on the falling edge.
module tb_display_scan_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       enable1, enable2;
  logic [3:0] blank_mask;
  logic [1:0] select1, select2;
  logic [3:0] digit_n1, digit_n2;
  logic       slot_tick1, slot_tick2;
  logic       frame_tick1, frame_tick2;

  display_scan_controller #(.CLK_DIV(8), .BLANK_CYCLES(2)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable1),
    .blank_mask (blank_mask),
    .select     (select1),
    .digit_n    (digit_n1),
    .slot_tick  (slot_tick1),
    .frame_tick (frame_tick1)
  );

  display_scan_controller #(.CLK_DIV(4), .BLANK_CYCLES(0)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable2),
    .blank_mask (4'b0000),
    .select     (select2),
    .digit_n    (digit_n2),
    .slot_tick  (slot_tick2),
    .frame_tick (frame_tick2)
  );

  localparam logic [7:0] IDLE_VEC = 8'b00_1111_0_0;

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];   // {watch dut2, select, digit_n, slot, frame}
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%b required=%b", name, cyc, act, exp);
    end
  endtask

  // Expected vector for cycle c of slot s (s counts from 0 since start).
  function automatic logic [7:0] exp_vec(input int s, input int c, input int blank,
                                         input logic [3:0] mask);
    logic [1:0] k;
    logic [1:0] g;
    logic [3:0] dn;
    k = 2'(s % 4);
    case (k)
      2'd0: g = 2'b00;
      2'd1: g = 2'b01;
      2'd2: g = 2'b11;
      default: g = 2'b10;
    endcase
    dn = 4'b1111;
    if (c >= blank && !mask[k]) dn = ~(4'b0001 << k);
    return {g, dn, (c == 0), (c == 0) && (k == 2'd0)};
  endfunction

  // Monitor: every falling edge with a pending expectation is compared.
  always @(negedge clk) begin
    logic [8:0] e;
    logic [7:0] act;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[8]) begin
        act = {select2, digit_n2, slot_tick2, frame_tick2};
        chk("scan4_vec", act, e[7:0]);
        chk("scan4_onehot", {7'd0, $countones(~digit_n2) <= 1}, 8'd1);
        if (e[5:2] != 4'b1111)
          chk("scan4_never_dark", {7'd0, digit_n2 != 4'b1111}, 8'd1);
      end else begin
        act = {select1, digit_n1, slot_tick1, frame_tick1};
        chk("scan8_vec", act, e[7:0]);
        chk("scan8_onehot", {7'd0, $countones(~digit_n1) <= 1}, 8'd1);
      end
    end
  end

  // ---------------- driver ----------------
  // One clock edge: apply inputs, queue the vector expected after the edge.
  task automatic step(input logic en1, input logic en2, input logic [3:0] mask,
                      input logic watch2, input logic [7:0] exp);
    @(negedge clk);
    #1;
    enable1    = en1;
    enable2    = en2;
    blank_mask = mask;
    exp_q.push_back({watch2, exp});
  endtask

  logic [3:0] m;

  initial begin
    rst_n      = 1'b0;
    enable1    = 1'b0;
    enable2    = 1'b0;
    blank_mask = 4'b0000;
    repeat (2) @(negedge clk);
    chk("reset_dut1", {select1, digit_n1, slot_tick1, frame_tick1}, IDLE_VEC);
    chk("reset_dut2", {select2, digit_n2, slot_tick2, frame_tick2}, IDLE_VEC);
    #1 rst_n = 1'b1;

    // Idle after reset with enable low
    repeat (3) step(1'b0, 1'b0, 4'b0000, 1'b0, IDLE_VEC);

    // Full frame plus one slot, no masking
    for (int s = 0; s < 5; s++)
      for (int c = 0; c < 8; c++)
        step(1'b1, 1'b0, 4'b0000, 1'b0, exp_vec(s, c, 2, 4'b0000));
    step(1'b0, 1'b0, 4'b0000, 1'b0, IDLE_VEC);

    // Masked digits 0 and 2 still get their slots
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 8; c++)
        step(1'b1, 1'b0, 4'b0101, 1'b0, exp_vec(s, c, 2, 4'b0101));
    step(1'b0, 1'b0, 4'b0000, 1'b0, IDLE_VEC);

    // Mid-slot mask change in slot 1, then drop enable at cnt=4 of slot 2
    for (int s = 0; s < 3; s++)
      for (int c = 0; c < 8; c++) begin
        if (s < 2 || c <= 4) begin
          m = (s == 1 && c >= 5) ? 4'b0010 : 4'b0000;
          step(1'b1, 1'b0, m, 1'b0, exp_vec(s, c, 2, m));
        end
      end
    step(1'b0, 1'b0, 4'b0000, 1'b0, IDLE_VEC);
    // Low-high on consecutive edges: clean restart at slot 0
    for (int c = 0; c < 5; c++)
      step(1'b1, 1'b0, 4'b0000, 1'b0, exp_vec(0, c, 2, 4'b0000));

    // Asynchronous reset during the show phase of slot 0 (cnt=4)
    @(negedge clk);
    #1;
    enable1 = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("async_reset", {select1, digit_n1, slot_tick1, frame_tick1}, IDLE_VEC);
    repeat (2) @(negedge clk);
    chk("reset_hold", {select1, digit_n1, slot_tick1, frame_tick1}, IDLE_VEC);
    #1 rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b0, 4'b0000, 1'b0, IDLE_VEC);
    for (int c = 0; c < 3; c++)
      step(1'b1, 1'b0, 4'b0000, 1'b0, exp_vec(0, c, 2, 4'b0000));
    step(1'b0, 1'b0, 4'b0000, 1'b0, IDLE_VEC);

    // Gapless instance: two frames with no blank phase
    for (int s = 0; s < 8; s++)
      for (int c = 0; c < 4; c++)
        step(1'b0, 1'b1, 4'b0000, 1'b1, exp_vec(s, c, 0, 4'b0000));
    step(1'b0, 1'b0, 4'b0000, 1'b1, IDLE_VEC);

    // Drain with a bounded wait
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Sequential scan driver for the four-digit seven-segment display. It sits directly upstream of the 4:1 display data multiplexer and drives that mux's 2-bit `select`, so each digit's segment data reaches the shared segment bus in turn. In lockstep it drives the active-low digit (anode) enables, with a blanking gap at each digit change to prevent ghosting. It also emits slot and frame strobes for downstream logic.

## Interface
Parameters:
- `CLK_DIV`, default 50000: clock cycles per digit slot. Legal range is ≥ 2.
- `BLANK_CYCLES`, default 500: cycles at the start of each slot during which all digits are off. Legal range is 0 ≤ `BLANK_CYCLES` < `CLK_DIV`.

Ports:
- `clk`  input  1  the single clock; all state is updated on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `enable`  input  1  scanning runs while this is high.
- `blank_mask`  input  4  bit k=1 suppresses digit k; its data still gets a slot.
- `select`  output  2  drives the downstream mux select.
- `digit_n`  output  4  active-low digit enables; bit k is digit k.
- `slot_tick`  output  1  one-cycle pulse in the first cycle of each slot.
- `frame_tick`  output  1  one-cycle pulse in the first cycle of slot 0.

## Operation
- The downstream mux decodes `select` in Gray order: 00→in_a, 01→in_b, 11→in_c, 10→in_d.
- Digit index k (0..3) therefore maps to `select` = 00, 01, 11, 10. Digit k shows the mux data input in position k (a, b, c, d).
- State:
  - `running` flag (IDLE/SCAN).
  - Slot counter `cnt`, 0..CLK_DIV-1, width $clog2(CLK_DIV).
  - Digit index k, 2 bits.
- Outputs are all registered. No combinational path exists from any input to any output.
- IDLE, on reset or while `enable` is low:
  - `select`=00, `digit_n`=4'b1111, `slot_tick`=0, `frame_tick`=0.
  - `cnt`=0, k=0.
- IDLE→SCAN: `enable` sampled high. The cycle after that edge is cycle 0 of slot 0.
- Within SCAN:
  - `cnt` increments every cycle.
  - When `cnt`=CLK_DIV-1, the next cycle has `cnt`=0 and k=k+1, wrapping from 3 to 0.
- Blank phase, `cnt` < BLANK_CYCLES: `digit_n`=4'b1111.
- Show phase, `cnt` ≥ BLANK_CYCLES: `digit_n` = ~(1<<k), forced to 4'b1111 if `blank_mask[k]`=1.
- `select` = gray(k) for the whole slot. It changes only at slot boundaries, always during a blank phase when BLANK_CYCLES > 0.
- `slot_tick` = 1 exactly when `cnt`=0.
- `frame_tick` = 1 exactly when `cnt`=0 and k=0. This includes the first slot after enable.
- SCAN→IDLE: `enable` sampled low. The next cycle shows IDLE outputs, and the next start resumes at slot 0, cycle 0.
- `blank_mask` is sampled every cycle. A change is reflected in `digit_n` one cycle later, even mid-slot.
- At most one bit of `digit_n` is ever low.

## Timing
- Frame period is 4·CLK_DIV cycles. Show time per digit is CLK_DIV−BLANK_CYCLES cycles.
- Start latency is one cycle: `enable` high at edge E gives `slot_tick`=1 in the cycle after E.
- Stop latency is one cycle: `enable` low at edge E gives `digit_n`=4'b1111 and `select`=00 in the cycle after E.
- `enable` toggled low-high on consecutive edges: restart at slot 0. No partial slot is kept.
- BLANK_CYCLES=0: no blank phase. `digit_n` switches directly from digit k to digit k+1 at the boundary.
- Asynchronous reset mid-scan: all outputs go to their IDLE values immediately, without waiting for a clock edge. After `rst_n` deasserts, the block stays IDLE until `enable` is sampled high.

## Test plan
All scenarios use CLK_DIV=8, BLANK_CYCLES=2 unless stated.
- Reset then start:
  - `rst_n` low, then high, `enable`=0 → `digit_n`=1111, `select`=00, both ticks 0.
  - Raise `enable` → next cycle `slot_tick`=`frame_tick`=1, `select`=00, `digit_n`=1111 for 2 cycles, then 1110 for 6 cycles.
- Full frame, `blank_mask`=0:
  - `select` sequence 00,01,11,10,00 at 8-cycle intervals.
  - `digit_n` show values 1110, 1101, 1011, 0111.
  - `slot_tick` every 8 cycles; `frame_tick` every 32 cycles.
- `blank_mask`=4'b0101 → slots 0 and 2 keep `digit_n`=1111 for all 8 cycles, while `select` still steps through 00 and 11. Slots 1 and 3 show 1101 and 0111.
- `enable` dropped at `cnt`=4 of slot 2 → next cycle `digit_n`=1111 and `select`=00. Re-raise → restart with `frame_tick`=1, `select`=00.
- `rst_n` pulsed low mid-show phase, without a clock edge → `digit_n`=1111 and `select`=00 asynchronously.
- CLK_DIV=4, BLANK_CYCLES=0 → `digit_n` is never 1111 during SCAN, and at most one bit is ever low (checked every cycle). The 4-cycle slots show 1110, 1101, 1011, 0111.
